mips_seq_alu: RTL and testbench

//  Parametrised, handshaked execute-stage ALU for the MIPS core.
//  - Single-cycle logic/arith/shift/compare ops return a registered result.
//  - MULT/MULTU and DIV/DIVU run iteratively and write the HI/LO register pair.
//  - Sits between the ID/EX register and the EX/MEM register; the hazard unit stalls on busy.

---
 rtl/mips_seq_alu_pkg.sv | 36 +++
 rtl/mips_iter_divider.sv | 57 +++++
 rtl/mips_seq_alu.sv | 214 +++++++++++++++++++++
 tb/tb_mips_seq_alu.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_seq_alu_pkg.sv
// rtl/mips_seq_alu_pkg.sv - Opcode and FSM state types shared by the sequential ALU
package mips_seq_alu_pkg;

  // Codes 0..10 are the original encodings; 11 and up were appended.
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_XNOR  = 5'd5,
    ALU_SLL   = 5'd6,
    ALU_SRL   = 5'd7,
    ALU_SLLV  = 5'd8,
    ALU_SRLV  = 5'd9,
    ALU_SRAV  = 5'd10,
    ALU_NOR   = 5'd11,
    ALU_SLT   = 5'd12,
    ALU_SLTU  = 5'd13,
    ALU_SRA   = 5'd14,
    ALU_MULT  = 5'd15,
    ALU_MULTU = 5'd16,
    ALU_DIV   = 5'd17,
    ALU_DIVU  = 5'd18,
    ALU_MFHI  = 5'd19,
    ALU_MFLO  = 5'd20
  } alu_sel_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_FIX     = 2'd3
  } alu_fsm_t;

endpackage

// File: rtl/mips_iter_divider.sv
// rtl/mips_iter_divider.sv - Unsigned restoring divider, one quotient bit per cycle
module mips_iter_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_dsr;
  logic [W:0]       w_diff;

  // Dividend bits shift out of r_quo into r_rem while quotient bits shift in.
  assign w_diff = {r_rem, r_quo[W-1]} - {1'b0, r_dsr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dsr  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dsr  <= i_divisor;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
      if (!w_diff[W]) begin
        r_rem <= w_diff[W-1:0];
        r_quo <= {r_quo[W-2:0], 1'b1};
      end else begin
        r_rem <= {r_rem[W-2:0], r_quo[W-1]};
        r_quo <= {r_quo[W-2:0], 1'b0};
      end
      if (r_cnt == '1) r_busy <= 1'b0;
    end
  end

  assign o_done      = r_busy & (r_cnt == '1);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/mips_seq_alu.sv
// rtl/mips_seq_alu.sv - Handshaked EX-stage ALU with iterative MULT/DIV; DIV/DIVU under MIPS_SEQ_ALU_DIV_EN
module mips_seq_alu
  import mips_seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  alu_sel_t              alu_sel,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [SHAMT_W-1:0]    shamt,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  zero,
  output logic                  illegal_op,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);
  localparam int W = DATA_WIDTH;

  alu_fsm_t       r_state, w_next;
  logic           r_mc_pulse;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2*W-1:0] r_prod;
  logic [W-1:0]   r_mcand;
  logic           r_neg_p;
  logic [W-1:0]   r_hi, r_lo, r_data_out;
  logic           r_zero, r_illegal, r_out_valid;

  logic           w_accept, w_is_mul, w_is_div, w_div_done, w_signed_op;
  logic           w_a_neg, w_b_neg;
  logic [W-1:0]   w_a_mag, w_b_mag;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_res;
  logic           w_illegal;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0]   w_fix_hi, w_fix_lo;

  assign busy      = (r_state != S_IDLE) | r_mc_pulse;
  assign in_ready  = ~busy;
  assign w_accept  = in_valid & in_ready;
  assign w_is_mul  = (alu_sel == ALU_MULT) | (alu_sel == ALU_MULTU);
  assign w_signed_op = (alu_sel == ALU_MULT) | (alu_sel == ALU_DIV);
  assign w_a_neg   = w_signed_op & data_in1[W-1];
  assign w_b_neg   = w_signed_op & data_in2[W-1];
  assign w_a_mag   = w_a_neg ? -data_in1 : data_in1;
  assign w_b_mag   = w_b_neg ? -data_in2 : data_in2;
  assign w_sum     = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_mcand} : '0);

`ifdef MIPS_SEQ_ALU_DIV_EN
  logic         r_is_div, r_neg_q, r_neg_r, r_div_zero;
  logic [W-1:0] r_dividend, w_quo, w_rem;
  logic         w_div_start;

  assign w_is_div    = (alu_sel == ALU_DIV) | (alu_sel == ALU_DIVU);
  assign w_div_start = (r_state == S_IDLE) & w_accept & w_is_div;

  mips_iter_divider #(.DATA_WIDTH(W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_done     (w_div_done),
    .o_quotient (w_quo),
    .o_remainder(w_rem)
  );
`else
  assign w_is_div   = 1'b0;
  assign w_div_done = 1'b0;
`endif

  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    case (alu_sel)
      ALU_ADD:   w_res = data_in1 + data_in2;
      ALU_SUB:   w_res = data_in1 - data_in2;
      ALU_AND:   w_res = data_in1 & data_in2;
      ALU_OR:    w_res = data_in1 | data_in2;
      ALU_XOR:   w_res = data_in1 ^ data_in2;
      ALU_XNOR:  w_res = ~(data_in1 ^ data_in2);
      ALU_NOR:   w_res = ~(data_in1 | data_in2);
      ALU_SLT:   w_res = {{(W-1){1'b0}}, ($signed(data_in1) < $signed(data_in2))};
      ALU_SLTU:  w_res = {{(W-1){1'b0}}, (data_in1 < data_in2)};
      ALU_SLL:   w_res = data_in2 << shamt;
      ALU_SRL:   w_res = data_in2 >> shamt;
      ALU_SRA:   w_res = $signed(data_in2) >>> shamt;
      ALU_SLLV:  w_res = data_in2 << data_in1[SHAMT_W-1:0];
      ALU_SRLV:  w_res = data_in2 >> data_in1[SHAMT_W-1:0];
      ALU_SRAV:  w_res = $signed(data_in2) >>> data_in1[SHAMT_W-1:0];
      ALU_MFHI:  w_res = r_hi;
      ALU_MFLO:  w_res = r_lo;
      ALU_MULT, ALU_MULTU: w_res = '0;
`ifdef MIPS_SEQ_ALU_DIV_EN
      ALU_DIV, ALU_DIVU:   w_res = '0;
`endif
      default:   w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_prod_fix = r_neg_p ? -r_prod : r_prod;
    {w_fix_hi, w_fix_lo} = w_prod_fix;
`ifdef MIPS_SEQ_ALU_DIV_EN
    // Divide by zero bypasses sign fixing so hi returns the raw dividend.
    if (r_is_div) begin
      if (r_div_zero) begin
        w_fix_lo = '1;
        w_fix_hi = r_dividend;
      end else begin
        w_fix_lo = r_neg_q ? -w_quo : w_quo;
        w_fix_hi = r_neg_r ? -w_rem : w_rem;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_next = S_MUL_RUN;
        else if (w_accept && w_is_div) w_next = S_DIV_RUN;
      end
      S_MUL_RUN: if (r_cnt == '1) w_next = S_FIX;
      S_DIV_RUN: if (w_div_done)  w_next = S_FIX;
      S_FIX:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mc_pulse  <= 1'b0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_mcand     <= '0;
      r_neg_p     <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_data_out  <= '0;
      r_zero      <= 1'b1;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef MIPS_SEQ_ALU_DIV_EN
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div_zero  <= 1'b0;
      r_dividend  <= '0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      r_mc_pulse  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
`ifdef MIPS_SEQ_ALU_DIV_EN
            r_is_div   <= w_is_div;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= (data_in2 == '0);
            r_dividend <= data_in1;
`endif
            if (w_is_mul) begin
              r_mcand <= w_a_mag;
              r_prod  <= {{W{1'b0}}, w_b_mag};
              r_neg_p <= w_a_neg ^ w_b_neg;
            end else if (!w_is_div) begin
              r_out_valid <= 1'b1;
              r_data_out  <= w_res;
              r_zero      <= (w_res == '0);
              r_illegal   <= w_illegal;
            end
          end
        end
        S_MUL_RUN: begin
          r_cnt  <= r_cnt + 1'b1;
          r_prod <= {w_sum, r_prod[W-1:1]};
        end
        S_FIX: begin
          r_hi        <= w_fix_hi;
          r_lo        <= w_fix_lo;
          r_data_out  <= w_fix_lo;
          r_zero      <= (w_fix_lo == '0);
          r_illegal   <= 1'b0;
          r_out_valid <= 1'b1;
          r_mc_pulse  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign data_out   = r_data_out;
  assign zero       = r_zero;
  assign illegal_op = r_illegal;
  assign hi_out     = r_hi;
  assign lo_out     = r_lo;

endmodule

// File: tb/tb_mips_seq_alu.sv
// tb/tb_mips_seq_alu.sv - Scoreboard bench for mips_seq_alu with a plain-arithmetic reference model
module tb_mips_seq_alu;
  import mips_seq_alu_pkg::*;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] d;
    logic         z;
    logic         ill;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic         in_ready, out_valid, zero, illegal_op, busy;
  alu_sel_t     alu_sel = ALU_ADD;
  logic [W-1:0] data_in1 = '0, data_in2 = '0;
  logic [4:0]   shamt = '0;
  logic [W-1:0] data_out, hi_out, lo_out;

  int           cyc = 0, nchk = 0, nfail = 0, mc_s = 1, mc_e = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  exp_t         scb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_seq_alu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .data_in1(data_in1), .data_in2(data_in2), .shamt(shamt),
    .out_valid(out_valid), .data_out(data_out), .zero(zero), .illegal_op(illegal_op),
    .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
  );

  function automatic void chk(string name, logic [W-1:0] got, logic [W-1:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endfunction

  // Returns latency; updates the architectural HI/LO model.
  function automatic int model(input alu_sel_t s, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [4:0] sh, output exp_t e);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    int              lat;
    logic            ill;
    logic [W-1:0]    d;
    lat = 1; ill = 1'b0; d = '0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a}; ub = {32'b0, b};
    case (s)
      ALU_ADD:  d = a + b;
      ALU_SUB:  d = a - b;
      ALU_AND:  d = a & b;
      ALU_OR:   d = a | b;
      ALU_XOR:  d = a ^ b;
      ALU_XNOR: d = ~(a ^ b);
      ALU_NOR:  d = ~(a | b);
      ALU_SLT:  d = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: d = (ua < ub) ? 32'd1 : 32'd0;
      ALU_SLL:  d = b << sh;
      ALU_SRL:  d = b >> sh;
      ALU_SRA:  d = W'(sb >>> sh);
      ALU_SLLV: d = b << a[4:0];
      ALU_SRLV: d = b >> a[4:0];
      ALU_SRAV: d = W'(sb >>> a[4:0]);
      ALU_MFHI: d = m_hi;
      ALU_MFLO: d = m_lo;
      ALU_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; d = m_lo; lat = W + 2; end
      ALU_MULTU: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; d = m_lo; lat = W + 2; end
`ifdef MIPS_SEQ_ALU_DIV_EN
      ALU_DIV: begin
        if (b == '0) begin m_lo = '1; m_hi = a; end
        else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
        d = m_lo; lat = W + 2;
      end
      ALU_DIVU: begin
        if (b == '0) begin m_lo = '1; m_hi = a; end
        else begin uq = ua / ub; ur = ua % ub; m_lo = uq[31:0]; m_hi = ur[31:0]; end
        d = m_lo; lat = W + 2;
      end
`endif
      default: ill = 1'b1;
    endcase
    e.d = d; e.z = (d == '0); e.ill = ill; e.hi = m_hi; e.lo = m_lo; e.cyc = 0;
    return lat;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("in_ready", {31'b0, in_ready}, (cyc >= mc_s && cyc <= mc_e) ? 32'd0 : 32'd1);
      chk("busy", {31'b0, busy}, (cyc >= mc_s && cyc <= mc_e) ? 32'd1 : 32'd0);
      if (out_valid === 1'b1) begin
        if (scb.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL unexpected_out_valid cyc=%0d got=1 want=0", cyc);
        end else begin
          e = scb.pop_front();
          chk("latency", W'(cyc), W'(e.cyc));
          chk("data_out", data_out, e.d);
          chk("zero", {31'b0, zero}, {31'b0, e.z});
          chk("illegal_op", {31'b0, illegal_op}, {31'b0, e.ill});
          chk("hi_out", hi_out, e.hi);
          chk("lo_out", lo_out, e.lo);
        end
      end
    end
  end

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic issue(input alu_sel_t s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh);
    exp_t e;
    int   lat;
    int   n;
    n = 0;
    alu_sel = s; data_in1 = a; data_in2 = b; shamt = sh; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      nchk++; nfail++;
      $display("FAIL accept_timeout cyc=%0d got=0 want=1", cyc);
      in_valid = 1'b0;
      return;
    end
    lat = model(s, a, b, sh, e);
    e.cyc = cyc + lat;
    if (lat > 1) begin mc_s = cyc + 1; mc_e = cyc + lat; end
    scb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (scb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("scoreboard_drained", W'(scb.size()), '0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] s5;
    int         n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_illegal", {31'b0, illegal_op}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);

    issue(ALU_ADD, 32'd5, 32'hFFFF_FFF9, 5'd0);
    issue(ALU_SUB, 32'd3, 32'd3, 5'd0);
    issue(ALU_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
    issue(ALU_MFHI, 32'd0, 32'd0, 5'd0);
    issue(ALU_MFLO, 32'd0, 32'd0, 5'd0);
    issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
    issue(ALU_DIVU, 32'h8000_0000, 32'd0, 5'd0);
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    issue(ALU_DIV, 32'd8, 32'd2, 5'd0);
    issue(ALU_SRAV, 32'd31, 32'h8000_0000, 5'd0);
    issue(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd0);
    issue(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0);
    issue(ALU_SRA, 32'd0, 32'hF000_0000, 5'd4);
    issue(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    issue(alu_sel_t'(5'd31), 32'd9, 32'd9, 5'd0);
    drain();

    // Reset ten cycles into a MULTU: no result, HI/LO cleared, ready again.
    alu_sel = ALU_MULTU; data_in1 = 32'd12345; data_in2 = 32'd678; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    mc_s = cyc + 1; mc_e = cyc + W + 2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1; mc_e = cyc;
    @(posedge clk); #1;
    rst = 1'b0; m_hi = '0; m_lo = '0;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_hi", hi_out, 32'd0);
    chk("abort_lo", lo_out, 32'd0);
    idle(W + 6);

    for (int i = 0; i < 150; i++) begin
      s5 = 5'($urandom_range(0, 23));
      issue(alu_sel_t'(s5), rnd_op(), rnd_op(), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
